// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: the requester and memory signals of mem_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the IFU, the LSU and the memory model, which together sit around the arbiter.
interface mem_arbiter_if #(
    parameter int XLEN = 64
);
    // Instruction-fetch requester
    logic            if_req_valid;
    logic            if_req_ready;
    logic [XLEN-1:0] if_addr;
    logic            if_rsp_valid;
    logic [31:0]     if_rsp_data;

    // Load/store requester
    logic            ls_req_valid;
    logic            ls_req_ready;
    logic            ls_wen;
    logic [XLEN-1:0] ls_addr;
    logic [XLEN-1:0] ls_wdata;
    logic [2:0]      ls_dlen;
    logic            ls_rsp_valid;
    logic [XLEN-1:0] ls_rsp_data;

    // Memory port
    logic            mem_r;
    logic            mem_w;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [2:0]      mem_dlen;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;

    modport slave (
        input  if_req_valid, if_addr,
        input  ls_req_valid, ls_wen, ls_addr, ls_wdata, ls_dlen,
        input  mem_rdata, mem_ack,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data,
        output mem_r, mem_w, mem_addr, mem_wdata, mem_dlen
    );

    modport master (
        output if_req_valid, if_addr,
        output ls_req_valid, ls_wen, ls_addr, ls_wdata, ls_dlen,
        output mem_rdata, mem_ack,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
        input  mem_r, mem_w, mem_addr, mem_wdata, mem_dlen
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single core memory port between the IFU and the LSU.
// Only one access is outstanding at a time. The access is sequenced by a
// three-state FSM (IDLE, IF_ACC, LS_ACC), and the state is visible on dbg_state.
//
// Handshake semantics: a request transfers on a rising edge where valid and
// ready are both high. Ready is combinational and is only ever high in IDLE.
// It is high for at most one requester, and only for one whose valid is high.
// After the transfer the requester may change its payload. Each accepted
// request produces exactly one rsp_valid pulse, one cycle after mem_ack.
//
// Optional feature: when MEM_ARB_RR_EN is defined, a tie between the two
// requesters is broken round-robin. When it is undefined, the LSU always wins
// a tie.
module mem_arbiter #(
    parameter int         XLEN    = 64,
    parameter logic [2:0] IF_DLEN = 3'b010
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output logic [1:0]    dbg_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IF_ACC = 2'd1;
    localparam logic [1:0] LS_ACC = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [2:0]      dlen_q, dlen_d;
    logic            wen_q, wen_d;
    logic            mem_r_q, mem_r_d;
    logic            mem_w_q, mem_w_d;
    logic            if_rsp_valid_q, if_rsp_valid_d;
    logic [31:0]     if_rsp_data_q, if_rsp_data_d;
    logic            ls_rsp_valid_q, ls_rsp_valid_d;
    logic [XLEN-1:0] ls_rsp_data_q, ls_rsp_data_d;

    logic            grant_if;
    logic            grant_ls;
    logic            idle_ok;

    // Grants are only given in IDLE and never while reset is applied.
    assign idle_ok = (state_q == IDLE) && !rst;

`ifdef MEM_ARB_RR_EN
    // last_grant_q: 1 = LSU was granted last, 0 = IFU was granted last
    logic last_grant_q, last_grant_d;

    // Round-robin tie-break: when both requesters are valid, the one not granted last wins
    always_comb begin
        grant_if     = 1'b0;
        grant_ls     = 1'b0;
        last_grant_d = last_grant_q;
        if (idle_ok) begin
            if (bus.if_req_valid && bus.ls_req_valid) begin
                grant_if = last_grant_q;
                grant_ls = !last_grant_q;
            end else begin
                grant_if = bus.if_req_valid;
                grant_ls = bus.ls_req_valid;
            end
        end
        if (grant_if) last_grant_d = 1'b0;
        if (grant_ls) last_grant_d = 1'b1;
    end

    // Remember the owner of each handshake; after reset the LSU counts as last granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_grant_q <= 1'b1;
        else     last_grant_q <= last_grant_d;
    end
`else
    // Fixed priority: the LSU wins a tie, and the IFU waits
    always_comb begin
        grant_ls = idle_ok && bus.ls_req_valid;
        grant_if = idle_ok && bus.if_req_valid && !bus.ls_req_valid;
    end
`endif

    // Next-state logic: latch the request, hold the strobe, capture the data on ack
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        dlen_d         = dlen_q;
        wen_d          = wen_q;
        mem_r_d        = mem_r_q;
        mem_w_d        = mem_w_q;
        if_rsp_valid_d = 1'b0;
        if_rsp_data_d  = if_rsp_data_q;
        ls_rsp_valid_d = 1'b0;
        ls_rsp_data_d  = ls_rsp_data_q;
        case (state_q)
            IDLE: begin
                if (grant_ls) begin
                    addr_d  = bus.ls_addr;
                    wdata_d = bus.ls_wdata;
                    dlen_d  = bus.ls_dlen;
                    wen_d   = bus.ls_wen;
                    mem_r_d = !bus.ls_wen;
                    mem_w_d = bus.ls_wen;
                    state_d = LS_ACC;
                end else if (grant_if) begin
                    addr_d  = bus.if_addr;
                    wdata_d = '0;
                    dlen_d  = IF_DLEN;
                    wen_d   = 1'b0;
                    mem_r_d = 1'b1;
                    mem_w_d = 1'b0;
                    state_d = IF_ACC;
                end
            end
            IF_ACC: begin
                if (bus.mem_ack) begin
                    // Select the 32-bit instruction from the 64-bit beat
                    if_rsp_data_d  = addr_q[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
                    if_rsp_valid_d = 1'b1;
                    mem_r_d        = 1'b0;
                    mem_w_d        = 1'b0;
                    state_d        = IDLE;
                end
            end
            LS_ACC: begin
                if (bus.mem_ack) begin
                    // A store returns zero; the LSU extends load data itself
                    ls_rsp_data_d  = wen_q ? '0 : bus.mem_rdata;
                    ls_rsp_valid_d = 1'b1;
                    mem_r_d        = 1'b0;
                    mem_w_d        = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: begin
                mem_r_d = 1'b0;
                mem_w_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            dlen_q         <= '0;
            wen_q          <= 1'b0;
            mem_r_q        <= 1'b0;
            mem_w_q        <= 1'b0;
            if_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= '0;
            ls_rsp_valid_q <= 1'b0;
            ls_rsp_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            dlen_q         <= dlen_d;
            wen_q          <= wen_d;
            mem_r_q        <= mem_r_d;
            mem_w_q        <= mem_w_d;
            if_rsp_valid_q <= if_rsp_valid_d;
            if_rsp_data_q  <= if_rsp_data_d;
            ls_rsp_valid_q <= ls_rsp_valid_d;
            ls_rsp_data_q  <= ls_rsp_data_d;
        end
    end

    assign bus.if_req_ready = grant_if;
    assign bus.ls_req_ready = grant_ls;
    assign bus.if_rsp_valid = if_rsp_valid_q;
    assign bus.if_rsp_data  = if_rsp_data_q;
    assign bus.ls_rsp_valid = ls_rsp_valid_q;
    assign bus.ls_rsp_data  = ls_rsp_data_q;
    assign bus.mem_r        = mem_r_q;
    assign bus.mem_w        = mem_w_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_dlen     = dlen_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter.
// Expected memory accesses and responses are queued before the stimulus is
// issued. The memory responder checks each strobe window, and the response
// monitor checks each rsp_valid pulse.
module tb_mem_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    mem_arbiter_if #(.XLEN(64)) bus ();

    mem_arbiter #(.XLEN(64), .IF_DLEN(3'b010)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    typedef struct {
        logic        r;
        logic        w;
        logic [2:0]  dlen;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          wt;     // cycles between first strobe cycle and ack cycle
        logic [63:0] rdata;  // data returned with the ack
    } mem_txn_t;

    mem_txn_t    mem_q[$];
    logic [64:0] exp_q[$];   // {1 = LSU / 0 = IFU, response data}

    int n_checks = 0;
    int n_pass   = 0;
    int stray_req  = 0;
    int stray_done = 0;

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- check helpers ----------------
    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic exp_mem(input logic r, input logic w, input logic [2:0] dlen,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input int wt, input logic [63:0] rdata);
        mem_txn_t t;
        t.r = r; t.w = w; t.dlen = dlen; t.addr = addr;
        t.wdata = wdata; t.wt = wt; t.rdata = rdata;
        mem_q.push_back(t);
    endtask

    task automatic exp_rsp(input logic is_ls, input logic [63:0] data);
        exp_q.push_back({is_ls, data});
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_if_req_ready", 64'(bus.if_req_ready), 64'd0);
        check_eq("rst_ls_req_ready", 64'(bus.ls_req_ready), 64'd0);
        check_eq("rst_if_rsp_valid", 64'(bus.if_rsp_valid), 64'd0);
        check_eq("rst_ls_rsp_valid", 64'(bus.ls_rsp_valid), 64'd0);
        check_eq("rst_if_rsp_data",  64'(bus.if_rsp_data),  64'd0);
        check_eq("rst_ls_rsp_data",  bus.ls_rsp_data,       64'd0);
        check_eq("rst_mem_r",        64'(bus.mem_r),        64'd0);
        check_eq("rst_mem_w",        64'(bus.mem_w),        64'd0);
        check_eq("rst_mem_addr",     bus.mem_addr,          64'd0);
        check_eq("rst_mem_wdata",    bus.mem_wdata,         64'd0);
        check_eq("rst_mem_dlen",     64'(bus.mem_dlen),     64'd0);
        check_eq("rst_state",        64'(dbg_state),        64'd0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_if(input int n, input logic [63:0] base);
        logic got;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            bus.if_addr      = base + 64'(i) * 64'd4;
            bus.if_req_valid = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 100 && !got; t++) begin
                @(negedge clk);
                got = bus.if_req_ready;
            end
            check_eq("if_grant", 64'(got), 64'd1);
            if (!got) break;
            @(posedge clk);
            #1;
        end
        bus.if_req_valid = 1'b0;
        bus.if_addr      = 64'h0BAD_0BAD_0BAD_0BAD;
    endtask

    task automatic drive_ls(input int n, input logic wen, input logic [63:0] base,
                            input logic [63:0] wdata, input logic [2:0] dlen);
        logic got;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            bus.ls_addr      = base + 64'(i) * 64'd8;
            bus.ls_wdata     = wdata + 64'(i);
            bus.ls_wen       = wen;
            bus.ls_dlen      = dlen;
            bus.ls_req_valid = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 100 && !got; t++) begin
                @(negedge clk);
                got = bus.ls_req_ready;
            end
            check_eq("ls_grant", 64'(got), 64'd1);
            if (!got) break;
            @(posedge clk);
            #1;
        end
        bus.ls_req_valid = 1'b0;
        bus.ls_addr      = 64'h0BAD_0BAD_0BAD_0BAD;
        bus.ls_wdata     = 64'h0BAD_0BAD_0BAD_0BAD;
        bus.ls_wen       = 1'b1;
        bus.ls_dlen      = 3'b111;
    endtask

    task automatic wait_drain(input int maxc);
        int t = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0 || dbg_state != 2'd0) && t < maxc) begin
            @(negedge clk);
            t++;
        end
        check_eq("drain", 64'(exp_q.size() + mem_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Watches a back-to-back fetch burst: strobe spacing and ready alongside rsp_valid
    task automatic b2b_watch(input int ncyc);
        int   rises = 0;
        int   last  = -1;
        logic prev  = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (bus.mem_r && !prev) begin
                if (last >= 0) check_eq("b2b_spacing", 64'(c - last), 64'd2);
                last = c;
                rises++;
            end
            prev = bus.mem_r;
            if (bus.if_rsp_valid && bus.if_req_valid)
                check_eq("b2b_ready_with_rsp", 64'(bus.if_req_ready), 64'd1);
        end
        check_eq("b2b_strobes", 64'(rises), 64'd3);
    endtask

    // ---------------- memory responder ----------------
    initial begin : responder
        mem_txn_t cur;
        int       cnt;
        logic     busy;
        logic     just_acked;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 64'hBADBADBADBADBAD0;
        busy       = 1'b0;
        just_acked = 1'b0;
        cnt        = 0;
        forever begin
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 64'hBADBADBADBADBAD0;
            if (rst) begin
                busy       = 1'b0;
                just_acked = 1'b0;
            end else begin
                check_eq("strobe_excl", 64'(bus.mem_r & bus.mem_w), 64'd0);
                if (just_acked) begin
                    check_eq("strobe_drop", 64'({bus.mem_r, bus.mem_w}), 64'd0);
                    just_acked = 1'b0;
                end else if (!busy && (bus.mem_r || bus.mem_w)) begin
                    if (mem_q.size() == 0) begin
                        check_eq("unexpected_strobe", 64'({bus.mem_r, bus.mem_w}), 64'd0);
                    end else begin
                        cur  = mem_q.pop_front();
                        busy = 1'b1;
                        cnt  = 0;
                    end
                end
                if (busy) begin
                    check_eq("mem_r",    64'(bus.mem_r),    64'(cur.r));
                    check_eq("mem_w",    64'(bus.mem_w),    64'(cur.w));
                    check_eq("mem_addr", bus.mem_addr,      cur.addr);
                    check_eq("mem_dlen", 64'(bus.mem_dlen), 64'(cur.dlen));
                    if (cur.w) check_eq("mem_wdata", bus.mem_wdata, cur.wdata);
                    if (cnt == cur.wt) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = cur.rdata;
                        busy       = 1'b0;
                        just_acked = 1'b1;
                    end else begin
                        cnt++;
                    end
                end else if (stray_done != stray_req && !(bus.mem_r || bus.mem_w)) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = 64'h5A5A5A5A5A5A5A5A;
                    stray_done++;
                end
            end
        end
    end

    // ---------------- response monitor and handshake invariants ----------------
    initial begin : monitor
        logic [64:0] e;
        logic [63:0] act;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check_eq("ready_excl", 64'(bus.if_req_ready & bus.ls_req_ready), 64'd0);
                check_eq("ready_needs_valid",
                         64'((bus.if_req_ready & !bus.if_req_valid) | (bus.ls_req_ready & !bus.ls_req_valid)),
                         64'd0);
                if (dbg_state != 2'd0)
                    check_eq("ready_in_access", 64'({bus.if_req_ready, bus.ls_req_ready}), 64'd0);
                if (bus.if_rsp_valid || bus.ls_rsp_valid) begin
                    check_eq("rsp_excl", 64'(bus.if_rsp_valid & bus.ls_rsp_valid), 64'd0);
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_rsp", 64'({bus.if_rsp_valid, bus.ls_rsp_valid}), 64'd0);
                    end else begin
                        e   = exp_q.pop_front();
                        act = bus.ls_rsp_valid ? bus.ls_rsp_data : {32'd0, bus.if_rsp_data};
                        check_eq("rsp_owner", 64'(bus.ls_rsp_valid), 64'(e[64]));
                        check_eq("rsp_data",  act, e[63:0]);
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin : main_seq
        rst              = 1'b1;
        bus.if_req_valid = 1'b0;
        bus.if_addr      = '0;
        bus.ls_req_valid = 1'b0;
        bus.ls_wen       = 1'b0;
        bus.ls_addr      = '0;
        bus.ls_wdata     = '0;
        bus.ls_dlen      = '0;

        // Power-on reset
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // Reset asserted while a fetch is outstanding; the access must vanish
        exp_mem(1'b1, 1'b0, 3'b010, 64'h0000_0000_8000_0040, 64'd0, 50, 64'h0);
        drive_if(1, 64'h0000_0000_8000_0040);
        repeat (3) @(negedge clk);
        check_eq("midrst_busy", 64'(bus.mem_r), 64'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stray_req++;   // late ack for the dropped access
        repeat (4) @(negedge clk);
        check_eq("midrst_state", 64'(dbg_state), 64'd0);

        // Fetch: upper half selected by addr[2]
        exp_mem(1'b1, 1'b0, 3'b010, 64'h0000_0000_8000_0004, 64'd0, 1, 64'h00500093_00000013);
        exp_rsp(1'b0, 64'h0000_0000_0050_0093);
        drive_if(1, 64'h0000_0000_8000_0004);
        wait_drain(40);

        // Load with a delayed ack
        exp_mem(1'b1, 1'b0, 3'b011, 64'h0000_0000_8000_1000, 64'd0, 3, 64'hDEADBEEF_CAFEF00D);
        exp_rsp(1'b1, 64'hDEADBEEF_CAFEF00D);
        drive_ls(1, 1'b0, 64'h0000_0000_8000_1000, 64'h7777_7777_7777_7777, 3'b011);
        wait_drain(40);

        // Store: the response data is zero whatever the memory returns
        exp_mem(1'b0, 1'b1, 3'b011, 64'h0000_0000_8000_2000, 64'h1122334455667788, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        exp_rsp(1'b1, 64'd0);
        drive_ls(1, 1'b1, 64'h0000_0000_8000_2000, 64'h1122334455667788, 3'b011);
        wait_drain(40);

        // Both requesters valid for two accesses each (LSU was granted last)
`ifdef MEM_ARB_RR_EN
        exp_mem(1'b1, 1'b0, 3'b010, 64'h0000_0000_8000_0100, 64'd0, 1, 64'hA1A1A1A1_A0A0A0A0);
        exp_rsp(1'b0, 64'h0000_0000_A0A0_A0A0);
        exp_mem(1'b1, 1'b0, 3'b011, 64'h0000_0000_8000_3000, 64'd0, 1, 64'hB0B0B0B0_B1B1B1B1);
        exp_rsp(1'b1, 64'hB0B0B0B0_B1B1B1B1);
        exp_mem(1'b1, 1'b0, 3'b010, 64'h0000_0000_8000_0104, 64'd0, 1, 64'hC1C1C1C1_C0C0C0C0);
        exp_rsp(1'b0, 64'h0000_0000_C1C1_C1C1);
        exp_mem(1'b1, 1'b0, 3'b011, 64'h0000_0000_8000_3008, 64'd0, 1, 64'hD0D0D0D0_D1D1D1D1);
        exp_rsp(1'b1, 64'hD0D0D0D0_D1D1D1D1);
`else
        exp_mem(1'b1, 1'b0, 3'b011, 64'h0000_0000_8000_3000, 64'd0, 1, 64'hB0B0B0B0_B1B1B1B1);
        exp_rsp(1'b1, 64'hB0B0B0B0_B1B1B1B1);
        exp_mem(1'b1, 1'b0, 3'b011, 64'h0000_0000_8000_3008, 64'd0, 1, 64'hD0D0D0D0_D1D1D1D1);
        exp_rsp(1'b1, 64'hD0D0D0D0_D1D1D1D1);
        exp_mem(1'b1, 1'b0, 3'b010, 64'h0000_0000_8000_0100, 64'd0, 1, 64'hA1A1A1A1_A0A0A0A0);
        exp_rsp(1'b0, 64'h0000_0000_A0A0_A0A0);
        exp_mem(1'b1, 1'b0, 3'b010, 64'h0000_0000_8000_0104, 64'd0, 1, 64'hC1C1C1C1_C0C0C0C0);
        exp_rsp(1'b0, 64'h0000_0000_C1C1_C1C1);
`endif
        fork
            drive_if(2, 64'h0000_0000_8000_0100);
            drive_ls(2, 1'b0, 64'h0000_0000_8000_3000, 64'd0, 3'b011);
        join
        wait_drain(80);

        // Stray ack in IDLE: no response, and the response data registers hold
        stray_req++;
        repeat (4) @(negedge clk);
        check_eq("stray_state",   64'(dbg_state),       64'd0);
        check_eq("hold_if_data",  64'(bus.if_rsp_data), 64'h0000_0000_C1C1_C1C1);
        check_eq("hold_ls_data",  bus.ls_rsp_data,      64'hD0D0D0D0_D1D1D1D1);

        // Back-to-back fetches with single-cycle acks
        exp_mem(1'b1, 1'b0, 3'b010, 64'h0000_0000_8000_0200, 64'd0, 0, 64'h11111111_22222222);
        exp_rsp(1'b0, 64'h0000_0000_2222_2222);
        exp_mem(1'b1, 1'b0, 3'b010, 64'h0000_0000_8000_0204, 64'd0, 0, 64'h33333333_44444444);
        exp_rsp(1'b0, 64'h0000_0000_3333_3333);
        exp_mem(1'b1, 1'b0, 3'b010, 64'h0000_0000_8000_0208, 64'd0, 0, 64'h55555555_66666666);
        exp_rsp(1'b0, 64'h0000_0000_6666_6666);
        fork
            drive_if(3, 64'h0000_0000_8000_0200);
            b2b_watch(16);
        join
        wait_drain(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
